// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream in, big-endian 32-bit words out
// to instruction memory, holding the core in reset while a load runs.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   start_i       begin a load session (honoured in IDLE/DONE/ERR)
//   len_i         number of words to load, latched with start_i
//   byte_valid_i  byte_data_i carries a byte
//   byte_data_i   stream byte
//   byte_ready_o  loader accepts a byte this cycle
//   mem_we_o      one-cycle write pulse per assembled word
//   mem_addr_o    word-aligned byte address of the write
//   mem_wdata_o   assembled word
//   cpu_rst_n_o   active-low reset to the PC / core
//   busy_o        session in progress
//   done_o        last session completed successfully
//   err_o         last session failed its checksum
//
// Build option IMEM_LOADER_CHECKSUM_EN: a trailing XOR checksum byte
// follows the data, adding the CHECK and ERR states.
module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd4
  } state_e;
`endif

  localparam logic [ADDR_W:0] ONE = 1;

  state_e          state_q;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] idx_q;
  logic [ADDR_W:0] idx_d;
  logic [1:0]      bcnt_q;
  logic [23:0]     word_q;
  logic [31:0]     word_d;
  logic [31:0]     addr_d;
  logic            ready_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            cpu_q;
  logic            busy_q;
  logic            done_q;
  logic            take;
  logic            go;
  logic            last;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      chk_q;
  logic            err_q;
`endif

  assign take   = byte_valid_i & ready_q;
  // busy_q tracks RECV/WRITE/CHECK exactly, so start is honoured
  // only from the three idle-like states.
  assign go     = start_i & ~busy_q;
  assign idx_d  = idx_q + ONE;
  assign word_d = {word_q, byte_data_i};
  assign addr_d = BASE_ADDR + {32'(idx_q) << 2};
  // len==0 reaches WRITE as a transit cycle with no write pulse.
  assign last   = (len_q == '0) || (idx_d == len_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      cpu_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
      if (go) begin
        len_q  <= len_i;
        idx_q  <= '0;
        bcnt_q <= '0;
        done_q <= 1'b0;
        busy_q <= 1'b1;
        cpu_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_q  <= '0;
        err_q  <= 1'b0;
`endif
        if (len_i == '0) begin
          state_q <= S_WRITE;
          ready_q <= 1'b0;
        end else begin
          state_q <= S_RECV;
          ready_q <= 1'b1;
        end
      end else begin
        unique case (state_q)
          S_IDLE: cpu_q <= 1'b1;
          S_RECV: begin
            if (take) begin
              bcnt_q <= bcnt_q + 2'd1;
              word_q <= word_d[23:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
              chk_q  <= chk_q ^ byte_data_i;
`endif
              if (bcnt_q == 2'd3) begin
                state_q <= S_WRITE;
                ready_q <= 1'b0;
                we_q    <= 1'b1;
                addr_q  <= addr_d;
                wdata_q <= word_d;
              end
            end
          end
          S_WRITE: begin
            idx_q <= idx_d;
            if (last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q <= S_CHECK;
              ready_q <= 1'b1;
`else
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              cpu_q   <= 1'b1;
`endif
            end else begin
              state_q <= S_RECV;
              ready_q <= 1'b1;
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          S_CHECK: begin
            if (take) begin
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              if (byte_data_i == chk_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                cpu_q   <= 1'b1;
              end else begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign byte_ready_o = ready_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign cpu_rst_n_o  = cpu_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed sessions, a byte-stream word model
// and a per-cycle monitor of write pulses and status rules.
module tb_imem_loader;

  localparam int          AW   = 8;
  localparam logic [31:0] BASE = 32'h0;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW:0]   len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .len_i        (len),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .cpu_rst_n_o  (cpu_rst_n),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: data bytes of the current session, grouped into words.
  int          mlen = 0;
  int          nb   = 0;
  logic [31:0] acc  = '0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr;
  logic [31:0] pend_data;
  logic [63:0] seen[$];

  task automatic model_clear(input int l);
    mlen = l;
    nb   = 0;
    acc  = '0;
    pend = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_we", mem_we, 0);
      pend = 1'b0;
    end else begin
      chk("we_timing", mem_we, pend);
      if (pend && mem_we) begin
        chk("waddr", mem_addr, pend_addr);
        chk("wdata", mem_wdata, pend_data);
      end
      if (mem_we) seen.push_back({mem_addr, mem_wdata});
      pend = 1'b0;
      chk("align", mem_addr[1:0], 0);
      if (busy) chk("cpu_held", cpu_rst_n, 0);
      if (byte_ready) chk("rdy_busy", busy, 1);
      if (done) chk("done_state", {busy, cpu_rst_n}, 2'b01);
      if (byte_valid && byte_ready && nb < 4 * mlen) begin
        acc = {acc[23:0], byte_data};
        nb++;
        if (nb % 4 == 0) begin
          pend      = 1'b1;
          pend_addr = BASE + 32'((nb / 4 - 1) * 4);
          pend_data = acc;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = (AW+1)'(l);
    model_clear(l);
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      step();
      n++;
    end
    chk("rdy_timeout", byte_ready, 1);
    step();
    byte_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || err) && n < 100) begin
      step();
      n++;
    end
    chk("end_timeout", done || err, 1);
  endtask

  logic [7:0] s8[8];
  int         t0;
  int         sz;

  initial begin
    s8 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    byte_valid = 1'b0;
    byte_data = '0;
    #2;
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cpu", cpu_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    #10 rst_n = 1'b1;
    #1 chk("cpu_before_edge", cpu_rst_n, 0);
    step();
    chk("cpu_after_edge", cpu_rst_n, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // len=2, back-to-back stream
    do_start(2);
    t0 = cyc;
    chk("start_busy", busy, 1);
    chk("start_cpu", cpu_rst_n, 0);
    chk("start_ready", byte_ready, 1);
    foreach (s8[i]) send(s8[i], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    wait_end();
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("latency", cyc - t0, 10);
`endif
    chk("a_done", done, 1);
    chk("a_err", err, 0);
    chk("a_cpu", cpu_rst_n, 1);
    chk("a_nw", seen.size(), 2);
    if (seen.size() >= 2) begin
      chk("a_w0", seen[0], 64'h00000000_12345678);
      chk("a_w1", seen[1], 64'h00000004_9ABCDEF0);
    end

    // same stream with 3-cycle gaps
    seen.delete();
    do_start(2);
    chk("b_done_clr", done, 0);
    foreach (s8[i]) send(s8[i], 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    wait_end();
    chk("b_done", done, 1);
    chk("b_nw", seen.size(), 2);
    if (seen.size() >= 2) begin
      chk("b_w0", seen[0], 64'h00000000_12345678);
      chk("b_w1", seen[1], 64'h00000004_9ABCDEF0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // checksum good then bad
    do_start(1);
    for (int i = 1; i <= 4; i++) send(8'(i), 0);
    send(8'h04, 0);
    chk("c_done", done, 1);
    chk("c_err", err, 0);
    chk("c_cpu", cpu_rst_n, 1);
    do_start(1);
    for (int i = 1; i <= 4; i++) send(8'(i), 0);
    send(8'h05, 0);
    chk("c_err_set", err, 1);
    chk("c_done_clr", done, 0);
    chk("c_cpu_low", cpu_rst_n, 0);
    chk("c_busy", busy, 0);
    repeat (3) step();
    chk("c_cpu_stays", cpu_rst_n, 0);
`endif

    // reset mid-session
    do_start(2);
    chk("d_err_clr", err, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    sz = seen.size();
    rst_n = 1'b0;
    model_clear(0);
    #1;
    chk("d_we", mem_we, 0);
    chk("d_busy", busy, 0);
    chk("d_cpu", cpu_rst_n, 0);
    chk("d_ready", byte_ready, 0);
    step();
    rst_n = 1'b1;
    chk("d_nw", seen.size(), sz);
    do_start(1);
    send(8'hAA, 0);
    send(8'hBB, 0);
    send(8'hCC, 0);
    send(8'hDD, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    wait_end();
    chk("d_done", done, 1);
    chk("d_nw2", seen.size(), sz + 1);
    if (seen.size() == sz + 1)
      chk("d_w", seen[sz], {BASE, 32'hAABBCCDD});

    // start held (and len changed) during RECV is ignored
    sz = seen.size();
    start = 1'b1;
    len = 1;
    model_clear(1);
    step();
    len = 3;
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    start = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h44, 0);
`endif
    wait_end();
    chk("e_done", done, 1);
    chk("e_nw", seen.size(), sz + 1);
    if (seen.size() == sz + 1)
      chk("e_w", seen[sz], {BASE, 32'h11223344});

    // len=0: one transit cycle then done
    sz = seen.size();
    do_start(0);
    chk("f_transit_done", done, 0);
    chk("f_transit_busy", busy, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00, 0);
`else
    step();
`endif
    chk("f_done", done, 1);
    chk("f_cpu", cpu_rst_n, 1);
    chk("f_err", err, 0);
    repeat (2) step();
    chk("f_nw", seen.size(), sz);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader: the write side of the instruction memory that the fetch path reads. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written into instruction memory at consecutive word-aligned byte addresses, the same addressing the PC uses. While a load is in progress it holds the processor's PC logic in reset; when the load completes it releases the processor, so fetch starts at address 0 with the new program.

## Interface
- ADDR_W, 8, word-index width; max program length 2^ADDR_W words
- BASE_ADDR, 32'h0, byte address of first word written
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a load session (sampled in IDLE, DONE, ERR)
- len  in  ADDR_W+1  number of words to load, sampled when start accepted
- byte_valid  in  1  byte_data valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  instruction-memory write enable, one-cycle pulse per word
- mem_addr  out  32  byte address, always word aligned
- mem_wdata  out  32  assembled word
- cpu_rst_n  out  1  active-low reset to PC/processor core
- busy  out  1  session in progress
- done  out  1  last session completed successfully (level)
- err  out  1  last session failed checksum (level; checksum build only)

## Operation
- States: IDLE, RECV, WRITE, CHECK (checksum build only), DONE, ERR.
- A byte is transferred when byte_valid && byte_ready. byte_ready is high only in RECV and CHECK.
- IDLE/DONE/ERR with start=1: latch len, clear word index, byte counter and checksum; clear done and err. Go to RECV, or go straight to the end path if len==0.
- RECV: shift bytes in big-endian order (first byte -> wdata[31:24]). After the 4th byte, go to WRITE.
- WRITE: mem_we=1 for exactly one cycle. mem_addr = BASE_ADDR + 4*index (32-bit wrap). mem_wdata = assembled word. The index then increments. If index+1 == len, take the end path; otherwise return to RECV.
- End path without checksum: DONE. With checksum: CHECK.
- CHECK: accept one byte. If it equals the XOR of all data bytes, go to DONE; otherwise go to ERR.
- start while busy (RECV/WRITE/CHECK) is ignored.
- cpu_rst_n is 0 in RECV, WRITE, CHECK and ERR, and 1 in IDLE and DONE.
- busy=1 in RECV, WRITE and CHECK.
- No partial word is ever written. A session aborted by reset leaves already-written words in memory.

## Timing
- All outputs are registered.
- Reset values: state IDLE, byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0.
- First clock after reset release: cpu_rst_n rises to 1 (IDLE).
- start accepted at edge N: busy=1, cpu_rst_n=0 and byte_ready=1 from edge N.
- 4th byte accepted at edge M: mem_we=1 and byte_ready=0 during cycle M..M+1. byte_ready returns at edge M+1.
- Peak throughput is 5 cycles per word.
- Final WRITE (no checksum), or accepted checksum byte: done=1, cpu_rst_n=1, busy=0 at the following edge.
- byte_valid low stalls RECV indefinitely, and byte count is preserved.
- Bytes presented outside RECV/CHECK are not consumed.
- len==0 and start: one transit cycle, then DONE. With checksum, CHECK expects byte 0x00.
- rst asserted mid-session immediately forces reset values, including mem_we=0.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: a trailing XOR checksum byte follows the data. CHECK and ERR states exist. On mismatch the loader enters ERR with err=1, and cpu_rst_n stays 0 until a new start.
- Undefined: no checksum byte, and no CHECK or ERR states. err is tied to 0 and the session ends after the last WRITE.

## Test plan
- Reset, then release → cpu_rst_n 0 then 1 after one edge; mem_we=0, done=0, busy=0.
- start, len=2; bytes 12 34 56 78 9A BC DE F0 streamed back-to-back → writes 0x12345678 @0x0 and 0x9ABCDEF0 @0x4, one mem_we each. cpu_rst_n is low throughout and rises with done; total 10 cycles after start.
- Same stream with byte_valid deasserted 3 cycles between bytes → identical writes, and no write before the 4th byte of each word.
- Checksum build, len=1, bytes 01 02 03 04, checksum 04 → done=1, err=0. Repeat with checksum 05 → err=1, done=0, cpu_rst_n stays 0.
- rst pulsed after the 2nd byte of a len=2 session → no mem_we. A new start, len=1, with 4 bytes AA BB CC DD writes 0xAABBCCDD @BASE_ADDR.
- start held high during RECV → ignored; len=0 start → done after one transit cycle with no mem_we.
